// File: rtl/spi_pkg.sv
// spi_pkg: shared state/command types and width defaults for the SPI slave.
package spi_pkg;

    localparam int unsigned FRAME_W_DEF = 10;
    localparam int unsigned TX_W_DEF    = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_cmd_e;

    function automatic logic is_rx_state(input spi_state_e s);
        return (s == WRITE) || (s == READ_ADD) || (s == READ_DATA);
    endfunction

endpackage

// File: rtl/spi_shift_rx.sv
// spi_shift_rx: MOSI serial-to-parallel register with bit counter.
// Captures FRAME_W bits MSB first, then presents the frame on rx_data with
// a one-cycle rx_valid strobe. rx_data holds until the next completed frame.
module spi_shift_rx
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               shift_en,
    input  logic               bit_in,
    output logic               last_bit,
    output logic               frame_done,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid
);

    localparam int unsigned CNT_W = $clog2(FRAME_W + 1);

    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-2:0] shreg;

    assign last_bit   = (bit_cnt == CNT_W'(FRAME_W - 1));
    assign frame_done = (bit_cnt == CNT_W'(FRAME_W));

    // Shift in one bit per enabled cycle; publish the frame on its last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (clr) begin
                bit_cnt <= '0;
            end else if (shift_en && !frame_done) begin
                shreg   <= {shreg[FRAME_W-3:0], bit_in};
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (last_bit) begin
                    rx_data  <= {shreg, bit_in};
                    rx_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_slave.sv
// spi_slave: clk-sampled SPI slave front end for a single-port RAM.
// Decodes {cmd, payload} frames from MOSI and, for a read-data frame,
// serializes the RAM reply onto MISO.
// Optional feature: define SPI_FRAME_ERR_EN to add the frame_err output.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEF,
    parameter int unsigned TX_W    = TX_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
`ifdef SPI_FRAME_ERR_EN
    output logic               frame_err,
`endif
    input  logic [TX_W-1:0]    tx_data,
    input  logic               tx_valid
);

    localparam int unsigned TXC_W = $clog2(TX_W + 1);

    spi_state_e       state;
    spi_state_e       state_nx;
    logic             rd_addr_flag;
    logic             shift_en;
    logic             last_bit;
    logic             frame_done;
    logic             tx_busy;
    logic             tx_done;
    logic [TXC_W-1:0] tx_cnt;
    logic [TX_W-1:0]  tx_latch;
    logic             tx_load;
    logic             tx_step;
    logic             reply_done;
    logic             set_flag;

    spi_shift_rx #(
        .FRAME_W (FRAME_W)
    ) u_shift_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (state == IDLE),
        .shift_en   (shift_en),
        .bit_in     (MOSI),
        .last_bit   (last_bit),
        .frame_done (frame_done),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_nx   = state;
        shift_en   = 1'b0;
        tx_load    = 1'b0;
        tx_step    = 1'b0;
        reply_done = 1'b0;
        set_flag   = 1'b0;
        case (state)
            IDLE: begin
                if (!SS_n) begin
                    state_nx = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (SS_n) begin
                    state_nx = IDLE;
                end else begin
                    shift_en = 1'b1;
                    if (!MOSI) begin
                        state_nx = WRITE;
                    end else if (rd_addr_flag) begin
                        state_nx = READ_DATA;
                    end else begin
                        state_nx = READ_ADD;
                    end
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (!frame_done) begin
                    // bit 0 is still taken when SS_n rises on its own cycle
                    shift_en = !SS_n || last_bit;
                    set_flag = last_bit && (state == READ_ADD);
                end else if (state == READ_DATA && !tx_done) begin
                    if (!tx_busy) begin
                        tx_load = tx_valid;
                    end else if (tx_cnt != '0) begin
                        tx_step = 1'b1;
                    end else begin
                        reply_done = 1'b1;
                    end
                end
                if (SS_n) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Read-address flag and MISO reply serializer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_flag <= 1'b0;
            MISO         <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            tx_cnt       <= '0;
            tx_latch     <= '0;
        end else begin
            if (set_flag) begin
                rd_addr_flag <= 1'b1;
            end else if (reply_done) begin
                rd_addr_flag <= 1'b0;
            end

            if (state_nx == IDLE) begin
                MISO    <= 1'b0;
                tx_busy <= 1'b0;
                tx_done <= 1'b0;
                tx_cnt  <= '0;
            end else if (tx_load) begin
                // MSB goes out straight away; the rest queue up in the latch
                MISO     <= tx_data[TX_W-1];
                tx_latch <= {tx_data[TX_W-2:0], 1'b0};
                tx_cnt   <= TXC_W'(TX_W - 1);
                tx_busy  <= 1'b1;
            end else if (tx_step) begin
                MISO     <= tx_latch[TX_W-1];
                tx_latch <= {tx_latch[TX_W-2:0], 1'b0};
                tx_cnt   <= tx_cnt - TXC_W'(1);
            end else if (reply_done) begin
                MISO    <= 1'b0;
                tx_busy <= 1'b0;
                tx_done <= 1'b1;
            end
        end
    end

`ifdef SPI_FRAME_ERR_EN
    logic mid_xfer;

    assign mid_xfer = (state == CHK_CMD)
                   || (is_rx_state(state) && !frame_done && !last_bit)
                   || ((state == READ_DATA) && frame_done && !tx_done && !reply_done);

    // Pulse when SS_n releases before the frame or its reply has finished.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= SS_n && mid_xfer;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized self-checking bench for spi_slave.
// A transaction-level model predicts rx_valid timing, rx_data, the MISO
// bit stream and the read-address flag from the frame/reply rules.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
    logic       frame_err;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic       model_flag;
    logic [9:0] model_rx;

    always #5 clk = ~clk;

    spi_slave #(
        .FRAME_W (10),
        .TX_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
`ifdef SPI_FRAME_ERR_EN
        .frame_err (frame_err),
`endif
        .tx_data   (tx_data),
        .tx_valid  (tx_valid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One SS_n-low transaction starting from IDLE at a negedge.
    // abort_k >= 0: SS_n rises after abort_k frame bits were sampled.
    // early_rel: SS_n rises on the bit-0 cycle. rst_obs > 0: reset at that observation.
    task automatic run_frame(input string tag, input logic [9:0] bits, input int abort_k,
                             input bit early_rel, input int tx_delay, input logic [7:0] tx_byte,
                             input bit stray, input int hold, input int rst_obs);
        int          kind;
        bit          completes;
        bit          replies;
        int          n_cyc;
        int          load_cyc;
        int          rxv_cnt;
        int          rxv_pos;
        int          ferr_cnt;
        logic        exp_bit;
        logic [63:0] miso_got;
        logic [63:0] miso_exp;

        kind      = !bits[9] ? 0 : (model_flag ? 2 : 1);
        completes = (abort_k < 0);
        replies   = completes && !early_rel && (kind == 2);
        load_cyc  = 11 + tx_delay;
        if (!completes)     n_cyc = abort_k + 2;
        else if (early_rel) n_cyc = 11;
        else if (replies)   n_cyc = load_cyc + 10 + hold;
        else                n_cyc = 12 + hold;

        rxv_cnt  = 0;
        rxv_pos  = -1;
        ferr_cnt = 0;
        miso_got = '0;
        miso_exp = '0;

        for (int n = 0; n < n_cyc; n++) begin
            SS_n     = (n == n_cyc - 1);
            MOSI     = (n >= 1 && n <= 10) ? bits[10 - n] : 1'($urandom_range(0, 1));
            tx_data  = 8'($urandom);
            tx_valid = 1'b0;
            if (replies && n == load_cyc) begin
                tx_valid = 1'b1;
                tx_data  = tx_byte;
            end else if (stray && (!replies || n < 11 || n > load_cyc)) begin
                tx_valid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (rx_valid) begin
                rxv_cnt++;
                rxv_pos = n + 1;
            end
            exp_bit = 1'b0;
            if (replies && n >= load_cyc && n <= load_cyc + 7) begin
                exp_bit = tx_byte[7 - (n - load_cyc)];
            end
            miso_got = {miso_got[62:0], MISO};
            miso_exp = {miso_exp[62:0], exp_bit};
`ifdef SPI_FRAME_ERR_EN
            if (frame_err) ferr_cnt++;
`endif
            if (n + 1 == rst_obs) begin
                check({tag, "/pre_rst_miso"}, 64'(MISO), 64'(exp_bit));
                #2 rst_n = 1'b0;
                #1;
                check({tag, "/rst_miso"}, 64'(MISO), 64'(0));
                check({tag, "/rst_rxv"}, 64'(rx_valid), 64'(0));
                check({tag, "/rst_rxdata"}, 64'(rx_data), 64'(0));
                SS_n       = 1'b1;
                tx_valid   = 1'b0;
                model_flag = 1'b0;
                model_rx   = '0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check({tag, "/post_rst_rxdata"}, 64'(rx_data), 64'(model_rx));
                return;
            end
        end

        if (completes) begin
            model_rx = bits;
            check({tag, "/rxv_pos"}, 64'(rxv_pos), 64'(11));
            if (kind == 1) model_flag = 1'b1;
            if (replies)   model_flag = 1'b0;
        end
        check({tag, "/rxv_cnt"}, 64'(rxv_cnt), 64'(completes ? 1 : 0));
        check({tag, "/rx_data"}, 64'(rx_data), 64'(model_rx));
        check({tag, "/miso_seq"}, miso_got, miso_exp);
`ifdef SPI_FRAME_ERR_EN
        check({tag, "/frame_err"}, 64'(ferr_cnt), 64'(completes ? 0 : 1));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        SS_n       = 1'b1;
        MOSI       = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        model_flag = 1'b0;
        model_rx   = '0;
        repeat (2) @(negedge clk);
        check("reset/rx_data", 64'(rx_data), 64'(0));
        check("reset/rx_valid", 64'(rx_valid), 64'(0));
        check("reset/miso", 64'(MISO), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed scenarios
        run_frame("wr_0a5",   10'h0A5, -1, 0, 0, 8'h00, 0, 2, -1);
        run_frame("rd_addr",  10'h207, -1, 0, 0, 8'h00, 0, 0, -1);
        run_frame("rd_c3",    10'h300 | 10'($urandom_range(0, 255)), -1, 0, 1, 8'hC3, 0, 0, -1);
        run_frame("rd_after", 10'h2AA, -1, 0, 0, 8'h00, 1, 1, -1);
        run_frame("rd_a5",    10'h3F0, -1, 0, 0, 8'hA5, 1, 2, -1);
        run_frame("abort_wr", 10'h155,  5, 0, 0, 8'h00, 0, 0, -1);
        run_frame("abort_ra", 10'h2F0,  3, 0, 0, 8'h00, 1, 0, -1);
        run_frame("abort_ck", 10'h0FF,  0, 0, 0, 8'h00, 0, 0, -1);
        run_frame("rd_chk",   10'h201, -1, 0, 0, 8'h00, 1, 0, -1);
        run_frame("abort_rd", 10'h3C3,  6, 0, 0, 8'h00, 0, 0, -1);
        run_frame("rd_3c",    10'h30F, -1, 0, 3, 8'h3C, 1, 1, -1);
        run_frame("b2b_1",    10'h012, -1, 0, 0, 8'h00, 0, 0, -1);
        run_frame("b2b_2",    10'h1FF, -1, 0, 0, 8'h00, 0, 0, -1);
        run_frame("early_ra", 10'h2C3, -1, 1, 0, 8'h00, 0, 0, -1);
        run_frame("rd_e7",    10'h3E7, -1, 0, 2, 8'hE7, 0, 0, -1);
        run_frame("stray_wr", 10'h0F0, -1, 0, 0, 8'h00, 1, 3, -1);

        // Randomized frames
        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            run_frame("rnd", 10'($urandom),
                      (r < 2) ? int'($urandom_range(0, 8)) : -1,
                      (r == 2),
                      int'($urandom_range(0, 3)), 8'($urandom),
                      1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), -1);
        end

        // Reset in the middle of a read-data reply
        if (!model_flag) run_frame("pre_rst_ra", 10'h200, -1, 0, 0, 8'h00, 0, 0, -1);
        run_frame("rst_reply",   10'h3FF, -1, 0, 0, 8'hFF, 0, 0, 15);
        run_frame("post_rst",    10'h2FF, -1, 0, 0, 8'h00, 1, 0, -1);
        run_frame("post_rst_rd", 10'h3A0, -1, 0, 1, 8'h5A, 0, 0, -1);

        // Reset in the middle of a write frame
        run_frame("rst_wr",       10'h0CC, -1, 0, 0, 8'h00, 0, 0, 5);
        run_frame("post_rst2",    10'h3FF, -1, 0, 0, 8'h00, 1, 0, -1);
        run_frame("post_rst2_rd", 10'h311, -1, 0, 0, 8'h81, 0, 1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 The block SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 The block SHALL have ports: SS_n  in  1  active-low slave select from the SPI master.
REQ-004 The block SHALL have ports: MOSI  in  1  serial data in, sampled on clk, MSB first.
REQ-005 The block SHALL have ports: MISO  out  1  serial data out, MSB first.
REQ-006 The block SHALL have ports: rx_data  out  10  assembled frame to the RAM, {cmd[1:0], payload[7:0]}.
REQ-007 The block SHALL have ports: rx_valid  out  1  one-cycle strobe qualifying rx_data.
REQ-008 The block SHALL have ports: tx_data  in  8  read data from the RAM.
REQ-009 The block SHALL have ports: tx_valid  in  1  qualifies tx_data.
REQ-010 The block SHALL have parameter: FRAME_W, default 10, bits per MOSI frame; TX_W, default 8, bits per MISO reply.

Function
REQ-011 The FSM SHALL have states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012 IDLE: SS_n low -> CHK_CMD next cycle; no bit sampled in this cycle.
REQ-013 CHK_CMD: MOSI sampled as rx bit 9; 0 -> WRITE, 1 with rd_addr_flag=0 -> READ_ADD, 1 with rd_addr_flag=1 -> READ_DATA.
REQ-014 WRITE/READ_ADD/READ_DATA SHALL sample remaining bits 8..0, one per cycle, via a 4-bit bit counter.
REQ-015 rx_valid SHALL assert for exactly one cycle, the cycle after bit 0 is sampled; rx_data SHALL hold its value until the next frame's rx_valid.
REQ-016 READ_ADD completion (rx_valid) SHALL set rd_addr_flag; READ_DATA reply completion SHALL clear it; WRITE SHALL not change it.
REQ-017 READ_DATA: after rx_valid, the block SHALL wait for tx_valid, latch tx_data, then drive MISO bits 7..0 on the 8 following cycles.
REQ-018 MISO SHALL be 0 whenever no reply bit is being driven.
REQ-019 After the frame (and reply, for READ_DATA) completes, the FSM SHALL remain in its state ignoring MOSI until SS_n rises.
REQ-020 SS_n high in any non-IDLE state SHALL force IDLE next cycle; a partial frame SHALL be discarded without rx_valid and rd_addr_flag left unchanged.
REQ-021 tx_valid arriving outside the READ_DATA wait window SHALL be ignored.
REQ-022 SS_n rising on the same cycle bit 0 is sampled SHALL still complete the frame (rx_valid issued), then IDLE.

Reset
REQ-023 rst_n low SHALL immediately set: state IDLE, bit counter 0, rx_data 0, rx_valid 0, MISO 0, rd_addr_flag 0, tx latch 0.
REQ-024 Reset mid-frame SHALL discard the frame; first frame after release SHALL be decoded from CHK_CMD with rd_addr_flag=0.

Configuration
REQ-025 Macro SPI_FRAME_ERR_EN defined: an extra output frame_err (1 bit, reset 0) SHALL pulse one cycle when SS_n rises mid-frame or mid-reply.
REQ-026 Macro SPI_FRAME_ERR_EN undefined: the frame_err port and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-027 A shared package spi_pkg SHALL hold the state enum, command encodings (WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11) and FRAME_W/TX_W defaults.
REQ-028 The serial-to-parallel register and counter SHALL be one sub-module, spi_shift_rx; FSM and MISO serializer stay in spi_slave.

Verification
REQ-029 Write: SS_n low, MOSI 0_00_1010_0101 -> rx_data=10'h0A5, rx_valid one cycle, MISO stays 0.
REQ-030 Read pair: frame 1_10_0000_0111 then 1_11_xxxx_xxxx with tx_valid/tx_data=8'hC3 -> second frame enters READ_DATA, MISO emits 1,1,0,0,0,0,1,1, rd_addr_flag cleared.
REQ-031 Abort: SS_n rises after 5 bits -> no rx_valid, IDLE next cycle, frame_err pulse when SPI_FRAME_ERR_EN defined.
REQ-032 Reset: rst_n low mid-READ_DATA reply -> MISO=0 and state IDLE same cycle, rd_addr_flag=0.
REQ-033 Back-to-back: two write frames separated by one SS_n-high cycle -> two rx_valid pulses, rx_data 10'h012 then 10'h1FF.
REQ-034 Stray tx_valid during WRITE -> ignored, MISO remains 0.
